// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave that bridges a byte-framed command/data protocol onto a simple
// register bus: byte 0 selects read/write and a start address, later bytes stream data.
module spi_slave_regs #(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_reset,
  input  logic              spi_read,
  input  logic              spi_write,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d;
  logic                miso_q, miso_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                re_pend_q, re_pend_d;
  logic                load_q, load_d;
  logic                inc_pend_q, inc_pend_d;
  logic [7:0]          rx_next;

  // Next-state and datapath: spi_reset pre-empts everything, IDLE ignores bit strobes.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    re_pend_d  = 1'b0;
    load_d     = re_q;
    inc_pend_d = 1'b0;
    rx_next    = {rx_q[6:0], mosi};

    if (spi_reset) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      rx_d      = 8'd0;
      tx_d      = 8'd0;
      miso_d    = 1'b0;
      load_d    = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (inc_pend_q) addr_d = addr_q + ADDR_W'(1);
      if (re_pend_q)  re_d   = 1'b1;

      if (spi_write) begin
        if (state_q == ST_RDATA) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
      // Read data lands one clock after reg_re; SPI pacing keeps it clear of shifts.
      if (load_q) tx_d = reg_rdata;

      if (spi_read) begin
        rx_d      = rx_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            ST_CMD: begin
              addr_d    = rx_next[ADDR_W-1:0];
              state_d   = rx_next[7] ? ST_RDATA : ST_WDATA;
              re_pend_d = rx_next[7];
            end
            ST_WDATA: begin
              we_d       = 1'b1;
              wdata_d    = rx_next;
              inc_pend_d = 1'b1;
            end
            ST_RDATA: begin
              addr_d    = addr_q + ADDR_W'(1);
              re_pend_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'd0;
      tx_q       <= 8'd0;
      miso_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      re_pend_q  <= 1'b0;
      load_q     <= 1'b0;
      inc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      re_pend_q  <= re_pend_d;
      load_q     <= load_d;
      inc_pend_q <= inc_pend_d;
    end
  end

  assign miso      = miso_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed + randomized bench for spi_slave_regs against a transaction-level model
// of the register traffic and the MISO bit stream.
module tb_spi_slave_regs;

  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_reset, spi_read, spi_write, mosi;
  logic          miso;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we, reg_re;
  logic [7:0]    reg_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0]    mem [128];
  logic [14:0]   obs_we [$];
  logic [14:0]   exp_we [$];
  logic [6:0]    obs_re [$];
  logic [6:0]    exp_re [$];
  logic [7:0]    txn_bytes [$];

  spi_slave_regs #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_reset (spi_reset),
    .spi_read  (spi_read),
    .spi_write (spi_write),
    .mosi      (mosi),
    .miso      (miso),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Register-file side: data valid exactly one clock after reg_re, noise otherwise.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    else        reg_rdata <= 8'($urandom);
  end

  // Record every bus strobe as it happens.
  always @(posedge clk) begin
    if (reg_we) obs_we.push_back({reg_addr, reg_wdata});
    if (reg_re) obs_re.push_back(reg_addr);
    if (reg_we || reg_re) chk("we_re_exclusive", 32'(reg_we & reg_re), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period: rising edge samples mosi, falling edge updates miso.
  task automatic spi_bit(input logic b, input logic exp_miso);
    mosi = b;
    spi_read = 1'b1;
    @(negedge clk);
    spi_read = 1'b0;
    mosi = 1'($urandom);
    tick(5);
    spi_write = 1'b1;
    @(negedge clk);
    spi_write = 1'b0;
    tick(5);
    chk("miso", 32'(miso), 32'(exp_miso));
  endtask

  // Full transaction from txn_bytes plus 'extra' trailing bits of a partial byte.
  task automatic do_txn(input int extra);
    int   nd;
    int   addr;
    int   n;
    logic isrd;
    logic e;
    logic stream [$];
    logic [7:0] cur;
    cur  = txn_bytes[0];
    nd   = txn_bytes.size() - 1;
    addr = int'(cur[6:0]);
    isrd = cur[7];
    if (!isrd) begin
      for (int k = 0; k < nd; k++) begin
        cur = txn_bytes[k+1];
        exp_we.push_back({7'((addr + k) % 128), cur});
      end
    end else begin
      for (int k = 0; k <= nd; k++) begin
        exp_re.push_back(7'((addr + k) % 128));
        cur = mem[(addr + k) % 128];
        for (int b = 7; b >= 0; b--) stream.push_back(cur[b]);
      end
    end
    spi_reset = 1'b1;
    @(negedge clk);
    spi_reset = 1'b0;
    tick(3);
    n = 0;
    for (int i = 0; i <= nd + 1; i++) begin
      int nb;
      nb  = (i <= nd) ? 8 : extra;
      cur = (i <= nd) ? txn_bytes[i] : 8'($urandom);
      for (int b = 7; b > 7 - nb; b--) begin
        e = (isrd && n >= 7) ? stream[n-7] : 1'b0;
        spi_bit(cur[b], e);
        n++;
      end
    end
  endtask

  task automatic check_queues();
    tick(6);
    chk("we_count", 32'(obs_we.size()), 32'(exp_we.size()));
    for (int i = 0; i < obs_we.size() && i < exp_we.size(); i++)
      chk("we_addr_data", 32'(obs_we[i]), 32'(exp_we[i]));
    chk("re_count", 32'(obs_re.size()), 32'(exp_re.size()));
    for (int i = 0; i < obs_re.size() && i < exp_re.size(); i++)
      chk("re_addr", 32'(obs_re[i]), 32'(exp_re[i]));
    obs_we.delete(); exp_we.delete(); obs_re.delete(); exp_re.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_miso"},  32'(miso),      32'd0);
    chk({tag, "_addr"},  32'(reg_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    chk({tag, "_we"},    32'(reg_we),    32'd0);
    chk({tag, "_re"},    32'(reg_re),    32'd0);
  endtask

  initial begin
    rst = 1'b1; spi_reset = 1'b0; spi_read = 1'b0; spi_write = 1'b0; mosi = 1'b0;
    reg_rdata = 8'd0;
    for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    tick(3);
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // Strobes before any spi_reset are ignored.
    for (int i = 0; i < 16; i++) spi_bit(1'($urandom), 1'b0);
    check_queues();

    // Write burst with auto-increment.
    txn_bytes = '{8'h05, 8'hA5, 8'h3C};
    do_txn(0);
    check_queues();
    chk("addr_after_write", 32'(reg_addr), 32'd7);

    // Read burst with pre-fetch; data = 0x80 + address.
    for (int a = 0; a < 128; a++) mem[a] = 8'(8'h80 + a);
    txn_bytes = '{8'h90, 8'h00, 8'h00};
    do_txn(0);
    check_queues();

    // Address wrap at the top of the map.
    txn_bytes = '{8'h7F, 8'h11, 8'h22};
    do_txn(0);
    check_queues();

    // Partial data byte discarded by a new transaction.
    txn_bytes = '{8'h02};
    do_txn(5);
    txn_bytes = '{8'h03, 8'h44};
    do_txn(0);
    check_queues();

    // rst during data bit 4 of a read, then strobes without spi_reset.
    txn_bytes = '{8'h90};
    do_txn(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("mid_rst");
    for (int i = 0; i < 16; i++) spi_bit(1'($urandom), 1'b0);
    check_queues();

    // Randomized transactions.
    for (int t = 0; t < 10; t++) begin
      int nd;
      for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
      nd = int'($urandom_range(0, 3));
      txn_bytes.delete();
      txn_bytes.push_back(8'($urandom));
      for (int k = 0; k < nd; k++) txn_bytes.push_back(8'($urandom));
      do_txn(int'($urandom_range(0, 7)));
      check_queues();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
